button_conditioner: RTL and testbench

//  Produces the command pulses that Game consumes: one instance conditions raw board buttons (down, left, right,

---
 rtl/button_conditioner.sv | 149 ++++++++++++++
 tb/tb_button_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns raw board buttons into clean command pulses for the game core.
//   Each button is handled on its own:
//     2-flop synchronizer -> debouncer -> press-edge pulse -> optional
//     hold-to-repeat (auto-shift).
//
// Ports
//   clk_100MHz : system clock
//   reset      : asynchronous active-low reset (0 = in reset)
//   btn_raw    : raw asynchronous button levels, 1 = pressed
//   freeze     : 1 = suppress every btn_pulse; tracking keeps running
//   btn_level  : debounced button levels (registered)
//   btn_pulse  : one-cycle command pulses, press + auto-repeat (registered)
//
// Reset release is expected to be synchronous to clk_100MHz already (done by
// the top-level reset bridge). No extra stage is added here, so a button held
// through reset gives its press pulse DEBOUNCE_CYCLES+2 edges after release.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int                N_BTN           = 6,
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                REPEAT_DELAY    = 30_000_000,
  parameter int                REPEAT_PERIOD   = 10_000_000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 6'b000111,
  parameter int                CNT_W           = 25
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             freeze,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // button released
    ONCE = 2'd1,  // pressed, no auto-repeat for this button
    HOLD = 2'd2,  // pressed, waiting for the first repeat
    RPT  = 2'd3   // pressed, repeating every REPEAT_PERIOD
  } rpt_state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [CNT_W-1:0] deb_cnt [N_BTN];
  logic [CNT_W-1:0] rpt_cnt [N_BTN];
  rpt_state_t       state   [N_BTN];

  // Debounced level as it will be after this edge. The repeat FSM works off
  // this value so the press pulse lands on the same edge the level rises, and
  // a release is seen in time to cancel a repeat pulse due on that edge.
  logic [N_BTN-1:0] level_next;
  logic [N_BTN-1:0] rise, fall;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != btn_level[i] && deb_cnt[i] == DEB_LAST) begin
        level_next[i] = sync2[i];
      end
    end
    rise = level_next & ~btn_level;
    fall = ~level_next & btn_level;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop, independent of
  // statement order. The per-button counters are plain registers (not a RAM),
  // so they are cleared by the asynchronous reset like any other flop.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i] <= '0;
        rpt_cnt[i] <= '0;
        state[i]   <= IDLE;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_level <= level_next;
      btn_pulse <= '0;

      for (int i = 0; i < N_BTN; i++) begin
        // Debounce: count consecutive cycles that disagree with the accepted
        // level; any agreeing cycle (a glitch back) restarts the count.
        if (sync2[i] == btn_level[i] || deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end

        // Repeat FSM. Pulses are gated by freeze only at the output; the
        // schedule itself keeps running, so a pulse due while frozen is lost.
        unique case (state[i])
          IDLE: begin
            if (rise[i]) begin
              btn_pulse[i] <= ~freeze;
              rpt_cnt[i]   <= '0;
              state[i]     <= REPEAT_MASK[i] ? HOLD : ONCE;
            end
          end
          ONCE: begin
            if (fall[i]) begin
              rpt_cnt[i] <= '0;
              state[i]   <= IDLE;
            end
          end
          HOLD: begin
            if (fall[i]) begin
              rpt_cnt[i] <= '0;
              state[i]   <= IDLE;
            end else if (rpt_cnt[i] == DLY_LAST) begin
              btn_pulse[i] <= ~freeze;
              rpt_cnt[i]   <= '0;
              state[i]     <= RPT;
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] + CNT_W'(1);
            end
          end
          RPT: begin
            if (fall[i]) begin
              rpt_cnt[i] <= '0;
              state[i]   <= IDLE;
            end else if (rpt_cnt[i] == PER_LAST) begin
              btn_pulse[i] <= ~freeze;
              rpt_cnt[i]   <= '0;
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            rpt_cnt[i] <= '0;
            state[i]   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed scenarios followed by random button activity. A reference model
//   derives the expected debounced level and pulse vector for every clock edge
//   from the input history (sliding-window debounce, time-since-rise repeat
//   schedule) and queues it; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int         N_BTN  = 6;
  localparam int         DEB    = 4;
  localparam int         RD     = 10;
  localparam int         RP     = 3;
  localparam logic [5:0] MASK   = 6'b000111;

  logic       clk_100MHz;
  logic       reset;
  logic [5:0] btn_raw;
  logic       freeze;
  logic [5:0] btn_level;
  logic [5:0] btn_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK),
    .CNT_W          (8)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .freeze    (freeze),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got level=%h pulse=%h want level=%h pulse=%h",
               name, cyc, act[11:6], act[5:0], exp[11:6], exp[5:0]);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] expq [$];
  logic [5:0]  rawq [$];   // raw inputs sampled at each edge since reset release
  logic [5:0]  m_lvl;
  int          m_k;
  int          m_start [6];

  // Pre-edge synchronizer output at edge k is the raw value of edge k-2.
  function automatic logic raw_at(int j, int b);
    if (j < 0) return 1'b0;
    return rawq[j][b];
  endfunction

  always @(posedge clk_100MHz) begin
    logic [5:0] pulse;
    logic       flip;
    logic       nl;
    int         d;
    cyc++;
    if (!reset) begin
      rawq.delete();
      m_k   = 0;
      m_lvl = '0;
      expq.push_back(12'h000);
    end else begin
      pulse = '0;
      for (int b = 0; b < 6; b++) begin
        // Level flips once the last DEB synchronized samples all oppose it.
        flip = 1'b1;
        for (int j = m_k - 1 - DEB; j <= m_k - 2; j++) begin
          if (j > m_k - 2 - DEB && raw_at(j, b) == m_lvl[b]) flip = 1'b0;
        end
        nl = flip ? ~m_lvl[b] : m_lvl[b];
        if (nl && !m_lvl[b]) begin
          pulse[b]   = 1'b1;
          m_start[b] = m_k;
        end else if (nl && m_lvl[b] && MASK[b]) begin
          d = m_k - m_start[b];
          if (d >= RD && ((d - RD) % RP) == 0) pulse[b] = 1'b1;
        end
        m_lvl[b] = nl;
      end
      rawq.push_back(btn_raw);
      m_k++;
      expq.push_back({m_lvl, freeze ? 6'h00 : pulse});
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow cycle=%0d got no expected entry want one", cyc);
      end else begin
        e = expq.pop_front();
        check("level_pulse", {btn_level, btn_pulse}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  initial begin
    reset   = 1'b0;
    btn_raw = '0;
    freeze  = 1'b0;

    // 1: all buttons held through reset, then released from reset
    btn_raw = 6'h3F;
    cycles(3);
    reset = 1'b1;
    cycles(14);
    btn_raw = '0;
    cycles(10);

    // 2: glitch on left during debounce
    btn_raw[1] = 1'b1; cycles(3);
    btn_raw[1] = 1'b0; cycles(1);
    btn_raw[1] = 1'b1; cycles(20);
    btn_raw[1] = 1'b0; cycles(10);

    // 3: hold down for auto-repeat, then release
    btn_raw[0] = 1'b1; cycles(40);
    btn_raw[0] = 1'b0; cycles(10);

    // 4: rotate button, no auto-repeat
    btn_raw[3] = 1'b1; cycles(40);
    btn_raw[3] = 1'b0; cycles(10);

    // 5: freeze across the press and first repeat
    btn_raw[2] = 1'b1;
    cycles(1);
    freeze = 1'b1;
    cycles(17);
    freeze = 1'b0;
    cycles(12);
    btn_raw[2] = 1'b0; cycles(10);

    // 6: reset pulse while holding down
    btn_raw[0] = 1'b1; cycles(11);
    reset = 1'b0;      cycles(3);
    reset = 1'b1;      cycles(20);
    btn_raw[0] = 1'b0; cycles(10);

    // random activity: slow presses, short glitches, freeze, rare reset
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 19) == 0) btn_raw[b] = ~btn_raw[b];
      end
      if ($urandom_range(0, 24) == 0) freeze = ~freeze;
      if ($urandom_range(0, 399) == 0) reset = 1'b0;
      else reset = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        btn_raw ^= 6'(1 << $urandom_range(0, 5));
        cycles(1);
        btn_raw ^= 6'(1 << $urandom_range(0, 5));
      end
      cycles(1);
    end

    reset   = 1'b1;
    btn_raw = '0;
    freeze  = 1'b0;
    cycles(12);
    @(posedge clk_100MHz);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
